// File: rtl/hazard_control_unit_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing unit.
package hazard_control_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam logic [3:0] PC_TAG = 4'd15;

    typedef struct packed {
        logic [3:0] rd;
        logic       rf_en;
    } dst_t;

    function automatic logic [31:0] nop_word();
        return 32'h0000_0000;
    endfunction

endpackage

// File: rtl/hazard_control_unit_forward_select.sv
// Per-operand bypass select: picks the youngest pending writer of a source tag.
module hazard_control_unit_forward_select
    import hazard_control_unit_pkg::*;
(
    input  logic [3:0] tag,
    input  logic       tag_valid,
    input  logic       ex_load,
    input  dst_t       ex,
    input  dst_t       mem,
    input  dst_t       wb,
    output logic [1:0] sel
);

    logic live;

    always_comb begin
        // r15 reads the PC, never a bypassed result
        live = tag_valid && (tag != PC_TAG);
        sel  = FWD_RF;
        if (live) begin
            if (ex.rf_en && !ex_load && (ex.rd == tag)) begin
                sel = FWD_EX;
            end else if (mem.rf_en && (mem.rd == tag)) begin
                sel = FWD_MEM;
            end else if (wb.rf_en && (wb.rd == tag)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer: stage enables, NOP insert, IF_ID flush, forwarding and
// data-memory wait handling with a timeout into a sticky halt.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       ID_rn,
    input  logic [3:0]       ID_rm,
    input  logic [3:0]       ID_rd,
    input  logic             ID_use_rn,
    input  logic             ID_use_rm,
    input  logic             ID_use_rd,
    input  logic             ID_branch_taken,
    input  logic [3:0]       EX_rd,
    input  logic [3:0]       MEM_rd,
    input  logic [3:0]       WB_rd,
    input  logic             EX_RF_enable,
    input  logic             MEM_RF_enable,
    input  logic             WB_RF_enable,
    input  logic             EX_load_instr,
    input  logic             MEM_DM_enable,
    input  logic             dm_ack,
    output logic             enable_pc,
    output logic             enable_if_id,
    output logic             enable_id_ex,
    output logic             enable_ex_mem,
    output logic             enable_mem_wb,
    output logic             sel_mux,
    output logic             flush_if_id,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       fwd_c,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             halted
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;
    logic              halted_q, halted_d;

    logic [4:0] en;
    logic       sel, flush, run;
    logic       stall_inc, flush_inc;
    logic       load_use, mem_stall;
    logic [1:0] fa, fb, fc;
    dst_t       ex_dst, mem_dst, wb_dst;

    assign ex_dst  = '{rd: EX_rd,  rf_en: EX_RF_enable};
    assign mem_dst = '{rd: MEM_rd, rf_en: MEM_RF_enable};
    assign wb_dst  = '{rd: WB_rd,  rf_en: WB_RF_enable};

    hazard_control_unit_forward_select u_fwd_a (
        .tag(ID_rn), .tag_valid(ID_use_rn), .ex_load(EX_load_instr),
        .ex(ex_dst), .mem(mem_dst), .wb(wb_dst), .sel(fa)
    );

    hazard_control_unit_forward_select u_fwd_b (
        .tag(ID_rm), .tag_valid(ID_use_rm), .ex_load(EX_load_instr),
        .ex(ex_dst), .mem(mem_dst), .wb(wb_dst), .sel(fb)
    );

    hazard_control_unit_forward_select u_fwd_c (
        .tag(ID_rd), .tag_valid(ID_use_rd), .ex_load(EX_load_instr),
        .ex(ex_dst), .mem(mem_dst), .wb(wb_dst), .sel(fc)
    );

    assign load_use = EX_load_instr && EX_RF_enable &&
                      ((ID_use_rn && (EX_rd == ID_rn)) ||
                       (ID_use_rm && (EX_rd == ID_rm)) ||
                       (ID_use_rd && (EX_rd == ID_rd)));

    assign mem_stall = MEM_DM_enable && !dm_ack;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        halted_d  = halted_q;
        en        = 5'b11111;
        sel       = 1'b0;
        flush     = 1'b0;
        run       = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        wait_inc  = wait_q + WAIT_W'(1);

        unique case (state_q)
            ST_RUN: run = 1'b1;
            ST_MEM_WAIT: begin
                if (dm_ack) begin
                    run     = 1'b1;
                    state_d = ST_RUN;
                    wait_d  = '0;
                end else begin
                    en        = '0;
                    stall_inc = 1'b1;
                    wait_d    = wait_inc;
                    if (wait_inc == WAIT_W'(MEM_TIMEOUT)) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                en  = '0;
                sel = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase

        // The entry cycle of a memory stall already counts as one wait cycle
        if (run) begin
            if (mem_stall) begin
                en        = '0;
                state_d   = ST_MEM_WAIT;
                wait_d    = WAIT_W'(1);
                stall_inc = 1'b1;
            end else if (load_use) begin
                en        = 5'b00111;
                sel       = 1'b1;
                stall_inc = 1'b1;
            end else if (ID_branch_taken) begin
                flush     = 1'b1;
                flush_inc = 1'b1;
            end
        end

        stall_d = (stall_inc && (stall_q != '1)) ? stall_q + CNT_W'(1) : stall_q;
        flush_d = (flush_inc && (flush_q != '1)) ? flush_q + CNT_W'(1) : flush_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RUN;
            wait_q   <= '0;
            stall_q  <= '0;
            flush_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            stall_q  <= stall_d;
            flush_q  <= flush_d;
            halted_q <= halted_d;
        end
    end

    assign {enable_pc, enable_if_id, enable_id_ex, enable_ex_mem, enable_mem_wb} =
        reset ? en : 5'b11111;
    assign sel_mux     = reset ? sel : 1'b0;
    assign flush_if_id = reset ? flush : 1'b0;
    assign fwd_a       = reset ? fa : FWD_RF;
    assign fwd_b       = reset ? fb : FWD_RF;
    assign fwd_c       = reset ? fc : FWD_RF;
    assign stall_count = stall_q;
    assign flush_count = flush_q;
    assign halted      = halted_q;

endmodule
